// File: rtl/branch_pred_ctrl_pkg.sv
// Shared types for the branch history memory controller: state encoding and
// the queued-update entry.
package branch_pred_ctrl_pkg;

    localparam int unsigned BP_ADDR_W = 6;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] addr;
        logic                 taken;
    } upd_entry_t;

endpackage

// File: rtl/branch_upd_fifo.sv
// Update queue for resolved branches. Exposes the raw entry array, read index and
// occupancy so the controller can search queued updates.
module branch_upd_fifo
    import branch_pred_ctrl_pkg::*;
#(
    parameter int unsigned UQ_DEPTH = 4,
    localparam int unsigned PTR_W   = $clog2(UQ_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  upd_entry_t       push_entry_i,
    input  logic             pop_i,
    output upd_entry_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o,
    output logic [PTR_W-1:0] rd_idx_o,
    output upd_entry_t       entries_o [UQ_DEPTH]
);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    upd_entry_t     mem_q [UQ_DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_i;
    end

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (count_o == (PTR_W+1)'(UQ_DEPTH));
    assign rd_idx_o  = rd_ptr_q[PTR_W-1:0];
    assign head_o    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign entries_o = mem_q;

endmodule

// File: rtl/branch_pred_ctrl.sv
// Single-port arbiter for the 1-bit branch history memory: clear sweep, lookups,
// buffered updates. Define UPD_BYPASS_EN to forward queued updates to lookups.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = BP_ADDR_W,
    parameter int unsigned ENTRIES  = 32,
    parameter int unsigned UQ_DEPTH = 4,
    parameter bit          INIT_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_ready,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_taken,
    output logic              upd_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wd,
    output logic              mem_we,
    input  logic              mem_rd,
    output logic              init_done
);

    localparam int unsigned       PTR_W    = $clog2(UQ_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

    bp_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              run;
    logic              q_full, q_empty, q_push, q_pop;
    upd_entry_t        q_head, q_in;
    logic              pred_src;

`ifdef UPD_BYPASS_EN
    logic [PTR_W:0]   q_count;
    logic [PTR_W-1:0] q_rd_idx;
    upd_entry_t       q_entries [UQ_DEPTH];
`endif

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (flush_req) begin
            state_d     = ST_INIT;
            cnt_d       = '0;
            init_done_d = 1'b0;
        end else if (state_q == ST_INIT) begin
            if (cnt_q == LAST_IDX) begin
                state_d     = ST_RUN;
                cnt_d       = '0;
                init_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // A full queue preempts lookups so updates cannot starve behind a busy fetch stage.
    always_comb begin
        mem_addr     = lookup_addr;
        mem_wd       = INIT_VAL;
        mem_we       = 1'b0;
        q_pop        = 1'b0;
        lookup_ready = 1'b0;
        upd_ready    = 1'b0;
        if (!run) begin
            mem_addr = cnt_q;
            mem_we   = rst_n;
        end else begin
            lookup_ready = !q_full;
            upd_ready    = !q_full;
            if (q_full || (!lookup_valid && !q_empty)) begin
                mem_addr = q_head.addr;
                mem_wd   = q_head.taken;
                mem_we   = 1'b1;
                q_pop    = 1'b1;
            end
        end
    end

    assign q_push = upd_valid && upd_ready && !flush_req;
    assign q_in   = '{addr: upd_addr, taken: upd_taken};

`ifdef UPD_BYPASS_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pred_src = mem_rd;
        idx      = '0;
        for (int unsigned i = 0; i < UQ_DEPTH; i++) begin
            idx = PTR_W'(32'(q_rd_idx) + i);
            if ((i < 32'(q_count)) && (q_entries[idx].addr == lookup_addr)) begin
                pred_src = q_entries[idx].taken;
            end
        end
    end
`else
    assign pred_src = mem_rd;
`endif

    assign pred_taken = (lookup_valid && lookup_ready) ? pred_src : 1'b0;

    branch_upd_fifo #(
        .UQ_DEPTH (UQ_DEPTH)
    ) u_upd_fifo (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (flush_req),
        .push_i       (q_push),
        .push_entry_i (q_in),
        .pop_i        (q_pop),
        .head_o       (q_head),
        .full_o       (q_full),
        .empty_o      (q_empty),
`ifdef UPD_BYPASS_EN
        .count_o      (q_count),
        .rd_idx_o     (q_rd_idx),
        .entries_o    (q_entries)
`else
        .count_o      (),
        .rd_idx_o     (),
        .entries_o    ()
`endif
    );

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl: expected memory writes and lookup results are
// queued at issue time and checked by a negedge monitor against a behavioural history memory.
module tb_branch_pred_ctrl;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush_req = 1'b0;
    logic              lookup_valid = 1'b0;
    logic [ADDR_W-1:0] lookup_addr = '0;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_addr = '0;
    logic              upd_taken = 1'b0;
    logic              lookup_ready, pred_taken, upd_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wd, mem_we, mem_rd, init_done;

    logic hist [64];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              val;
    } exp_t;

    exp_t wq[$];
    exp_t lq[$];

    always #5 clk = ~clk;

    branch_pred_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_req    (flush_req),
        .lookup_valid (lookup_valid),
        .lookup_addr  (lookup_addr),
        .lookup_ready (lookup_ready),
        .pred_taken   (pred_taken),
        .upd_valid    (upd_valid),
        .upd_addr     (upd_addr),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd),
        .init_done    (init_done)
    );

    // History memory: filled with ones while reset is held so the sweep is observable.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) hist[i] <= 1'b1;
        end else if (mem_we) begin
            hist[mem_addr] <= mem_wd;
        end
    end
    assign mem_rd = hist[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic v);
        wq.push_back('{addr: a, val: v});
    endtask

    task automatic exp_lk(input logic [ADDR_W-1:0] a, input logic v);
        lq.push_back('{addr: a, val: v});
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0d data %0b expected none at %0t",
                             mem_addr, mem_wd, $time);
                end else begin
                    e = wq.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(e.addr));
                    check("write_data", 32'(mem_wd), 32'(e.val));
                end
            end
            if (lookup_valid && lookup_ready) begin
                if (lq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_lookup: got addr %0d expected none at %0t",
                             lookup_addr, $time);
                end else begin
                    e = lq.pop_front();
                    check("lookup_mem_addr", 32'(mem_addr), 32'(e.addr));
                    check("pred_taken", 32'(pred_taken), 32'(e.val));
                end
            end else begin
                check("pred_idle_zero", 32'(pred_taken), 32'd0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_lookup_ready", 32'(lookup_ready), 32'd0);
        check("rst_upd_ready", 32'(upd_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wd", 32'(mem_wd), 32'd0);

        // Clear sweep: 32 writes of 0 to addresses 0..31
        for (int i = 0; i < 32; i++) exp_wr(ADDR_W'(i), 1'b0);
        rst_n = 1'b1;
        repeat (31) tick();
        check("sweep_init_done_low", 32'(init_done), 32'd0);
        check("sweep_lookup_ready", 32'(lookup_ready), 32'd0);
        check("sweep_upd_ready", 32'(upd_ready), 32'd0);
        tick();
        check("sweep_init_done_high", 32'(init_done), 32'd1);
        check("run_lookup_ready", 32'(lookup_ready), 32'd1);

        // Lookup after sweep
        lookup_valid = 1'b1; lookup_addr = 6'd5; exp_lk(6'd5, 1'b0);
        tick();
        lookup_valid = 1'b0;

        // Single update, drained on the next idle cycle, then visible to a lookup
        upd_valid = 1'b1; upd_addr = 6'd7; upd_taken = 1'b1; exp_wr(6'd7, 1'b1);
        #1 check("upd_ready_idle", 32'(upd_ready), 32'd1);
        tick();
        upd_valid = 1'b0;
        #1 check("drain_next_cycle", 32'(mem_we), 32'd1);
        tick();
        lookup_valid = 1'b1; lookup_addr = 6'd7; exp_lk(6'd7, 1'b1);
        tick();
        lookup_valid = 1'b0;

        // Fill the queue under continuous lookups; full forces a drain
        lookup_valid = 1'b1; lookup_addr = 6'd20;
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1'b1; upd_addr = ADDR_W'(10 + k); upd_taken = 1'b1;
            exp_wr(ADDR_W'(10 + k), 1'b1);
            exp_lk(6'd20, 1'b0);
            #1 check("fill_upd_ready", 32'(upd_ready), 32'd1);
            tick();
        end
        upd_valid = 1'b0;
        #1 check("full_upd_ready", 32'(upd_ready), 32'd0);
        check("full_lookup_ready", 32'(lookup_ready), 32'd0);
        check("full_drain_we", 32'(mem_we), 32'd1);
        tick();
        exp_lk(6'd20, 1'b0);
        #1 check("after_full_lookup_ready", 32'(lookup_ready), 32'd1);
        check("after_full_upd_ready", 32'(upd_ready), 32'd1);
        tick();
        lookup_valid = 1'b0;
        repeat (4) tick();

        // Push and pop in one cycle at occupancy 3; same-address updates commit in order
        lookup_valid = 1'b1; lookup_addr = 6'd20;
        upd_valid = 1'b1;
        upd_addr = 6'd9;  upd_taken = 1'b1; exp_wr(6'd9, 1'b1);  exp_lk(6'd20, 1'b0); tick();
        upd_addr = 6'd9;  upd_taken = 1'b0; exp_wr(6'd9, 1'b0);  exp_lk(6'd20, 1'b0); tick();
        upd_addr = 6'd30; upd_taken = 1'b1; exp_wr(6'd30, 1'b1); exp_lk(6'd20, 1'b0); tick();
        lookup_valid = 1'b0;
        upd_addr = 6'd31; upd_taken = 1'b1; exp_wr(6'd31, 1'b1);
        #1 check("pushpop_upd_ready", 32'(upd_ready), 32'd1);
        check("pushpop_drain_we", 32'(mem_we), 32'd1);
        tick();
        #1 check("occ3_upd_ready", 32'(upd_ready), 32'd1);
        lookup_valid = 1'b1; exp_lk(6'd20, 1'b0);
        upd_addr = 6'd40; upd_taken = 1'b1; exp_wr(6'd40, 1'b1);
        tick();
        upd_valid = 1'b0; lookup_valid = 1'b0;
        #1 check("occ4_upd_ready", 32'(upd_ready), 32'd0);
        repeat (5) tick();
        lookup_valid = 1'b1; lookup_addr = 6'd9; exp_lk(6'd9, 1'b0);
        tick();
        lookup_valid = 1'b0;

        // Flush with three queued updates; the flush-cycle update is dropped
        lookup_valid = 1'b1; lookup_addr = 6'd20;
        upd_valid = 1'b1; upd_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            upd_addr = ADDR_W'(21 + k); exp_lk(6'd20, 1'b0);
            tick();
        end
        flush_req = 1'b1; upd_addr = 6'd24; exp_lk(6'd20, 1'b0);
        #1 check("flush_cycle_no_write", 32'(mem_we), 32'd0);
        tick();
        flush_req = 1'b0; upd_valid = 1'b0; lookup_valid = 1'b0;
        for (int i = 0; i < 32; i++) exp_wr(ADDR_W'(i), 1'b0);
        #1 check("flush_init_done", 32'(init_done), 32'd0);
        check("flush_lookup_ready", 32'(lookup_ready), 32'd0);
        check("flush_upd_ready", 32'(upd_ready), 32'd0);
        repeat (32) tick();
        check("reflush_init_done", 32'(init_done), 32'd1);
        lookup_valid = 1'b1;
        lookup_addr = 6'd7;  exp_lk(6'd7, 1'b0);  tick();
        lookup_addr = 6'd21; exp_lk(6'd21, 1'b0); tick();
        lookup_addr = 6'd24; exp_lk(6'd24, 1'b0); tick();
        lookup_addr = 6'd31; exp_lk(6'd31, 1'b0); tick();
        lookup_valid = 1'b0;

        // Lookup hitting a still-queued update
        upd_valid = 1'b1; upd_addr = 6'd3; upd_taken = 1'b1; exp_wr(6'd3, 1'b1);
        tick();
        upd_valid = 1'b0;
        lookup_valid = 1'b1; lookup_addr = 6'd3;
`ifdef UPD_BYPASS_EN
        exp_lk(6'd3, 1'b1);
`else
        exp_lk(6'd3, 1'b0);
`endif
        tick();
        lookup_valid = 1'b0;
        tick();
        lookup_valid = 1'b1; lookup_addr = 6'd3; exp_lk(6'd3, 1'b1);
        tick();
        lookup_valid = 1'b0;

        repeat (3) tick();
        check("writes_outstanding", 32'(wq.size()), 32'd0);
        check("lookups_outstanding", 32'(lq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
Controller for the single-ported 1-bit branch history memory, where one address drives both read and write. It shares that port between fetch-stage prediction lookups and execute-stage outcome updates. Updates are buffered in a small queue and drained on idle cycles. After reset or flush it sequences a clearing sweep over every entry. It sits between the IF/EX pipeline stages and the history memory instance.

Parameters:
ADDR_W, 6, width of the history-memory address
ENTRIES, 32, number of valid history entries cleared by the sweep (≤ 2^ADDR_W)
UQ_DEPTH, 4, update-queue depth (power of two, ≥ 2)
INIT_VAL, 0, bit written to every entry during the sweep (0 = predict not-taken)

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous, active-low reset
flush_req  in  1  one-cycle pulse: discard queued updates and re-run the clear sweep
lookup_valid  in  1  IF-stage prediction request
lookup_addr  in  ADDR_W  index of the branch being predicted
lookup_ready  out  1  lookup is served this cycle
pred_taken  out  1  prediction; valid when lookup_valid && lookup_ready
upd_valid  in  1  EX-stage resolved-branch update
upd_addr  in  ADDR_W  index to update
upd_taken  in  1  resolved outcome
upd_ready  out  1  queue accepts the update this cycle
mem_addr  out  ADDR_W  to the history memory address
mem_wd  out  1  to the history memory write data
mem_we  out  1  to the history memory write enable
mem_rd  in  1  from the history memory combinational read output
init_done  out  1  high when in RUN

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, sweep counter=0, queue empty.
  - Outputs: lookup_ready=0, upd_ready=0, init_done=0, mem_we=0, mem_addr=0, mem_wd=INIT_VAL.
- States are INIT and RUN.
- INIT:
  - Each cycle: mem_addr=sweep counter, mem_wd=INIT_VAL, mem_we=1; counter increments.
  - When the counter reaches ENTRIES-1, that write completes and the next state is RUN.
  - Sweep takes exactly ENTRIES cycles.
  - lookup_ready=0 and upd_ready=0 throughout INIT.
- RUN, port arbitration (combinational, fixed priority):
  1. Queue full and not empty: drain the head (mem_addr=head addr, mem_wd=head taken, mem_we=1, pop). lookup_ready=0. Prevents update starvation.
  2. Else lookup_valid=1: mem_addr=lookup_addr, mem_we=0, lookup_ready=1, pred_taken=mem_rd. Zero-cycle latency.
  3. Else queue not empty: drain the head as in 1.
  4. Else idle: mem_we=0, mem_addr=lookup_addr.
- lookup_ready=1 whenever in RUN and the queue is not full.
- pred_taken=0 when no lookup is served.
- Update queue:
  - FIFO with pointers of width log2(UQ_DEPTH)+1.
  - upd_ready = RUN && !full.
  - A push occurs when upd_valid && upd_ready.
  - Push and pop in the same cycle are both legal; occupancy is unchanged.
  - Pop from an empty queue never occurs.
  - Updates to the same address commit in arrival order; the last one wins.
- Write timing: a drained update is visible to a lookup on the following cycle.
- flush_req in RUN:
  - Next cycle: state=INIT, counter=0, queue emptied.
  - Any update presented in the flush cycle is dropped.
  - A lookup in the flush cycle is still served normally.
- flush_req in INIT restarts the sweep from 0.
- rst_n asserted mid-sweep or mid-drain aborts immediately; no partial-state guarantees beyond the reset values.

Optional Feature:
UPD_BYPASS_EN
- Defined: when a lookup is served and any queued entry matches lookup_addr, pred_taken = taken bit of the youngest matching entry; otherwise mem_rd. The prediction then reflects all accepted updates.
- Undefined: pred_taken=mem_rd always; stale predictions are possible until the drain.

Decomposition:
- Shared package holds: ADDR_W default, the state encoding (ST_INIT, ST_RUN), and the update-entry typedef {addr, taken}.
- One natural sub-module: branch_upd_fifo (parameterised UQ_DEPTH; push/pop, full/empty, entry-array output for the bypass search).
- Arbitration and the sweep FSM stay in the top module.

Test Plan:
- Reset release with ENTRIES=32: mem_we=1 for exactly 32 cycles, mem_addr 0..31, mem_wd=0; init_done rises on cycle 33; then lookup at addr 5 gives pred_taken=0.
- Update addr 7 taken=1 with lookup_valid=0: written the next cycle; lookup addr 7 one cycle later gives pred_taken=1.
- lookup_valid held at 1 while 4 updates are pushed: upd_ready falls after the 4th; the next cycle has lookup_ready=0 and the head is drained; lookup_ready returns to 1 once not full.
- Push and pop in the same cycle at occupancy 3: occupancy stays 3 and upd_ready stays 1. Two updates to addr 9 (1 then 0) commit in order; the final read is 0.
- flush_req with 3 queued updates: the queue empties, the sweep reruns for 32 cycles, and the updated addresses read INIT_VAL afterwards.
- Bypass: with UPD_BYPASS_EN, queued update addr 3 taken=1 and same-cycle lookup addr 3 gives pred_taken=1; without the macro, pred_taken=0.
